// File: rtl/conv_core_param_pkg.sv
// Shared types and sizing helpers for the parametrised convolution core.
package conv_core_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_K      = 3;
  localparam int DEF_OUT_CH = 4;

  // Full-precision psum width: a K*K sum of WIDTH x WIDTH signed products cannot overflow it.
  function automatic int acc_w(input int width, input int k);
    return 2 * width + $clog2(k * k);
  endfunction

endpackage

// File: rtl/conv_core_param_if.sv
// Weight-load, window and psum bundle between window generator, conv core and writeback.
interface conv_core_param_if #(
  parameter int WIDTH  = 8,
  parameter int K      = 3,
  parameter int OUT_CH = 4
);
  import conv_core_pkg::*;

  localparam int ACC_W = acc_w(WIDTH, K);

  logic                      weight_load;
  logic [OUT_CH*WIDTH-1:0]   weight_in;
  logic                      weight_load_done;
  logic                      act_valid;
  logic                      act_ready;
  logic [K*K*WIDTH-1:0]      act_win;
  logic [OUT_CH*ACC_W-1:0]   psum_out;
  logic                      psum_vld;

  modport master (
    output weight_load, weight_in, act_valid, act_win,
    input  weight_load_done, act_ready, psum_out, psum_vld
  );

  modport slave (
    input  weight_load, weight_in, act_valid, act_win,
    output weight_load_done, act_ready, psum_out, psum_vld
  );

endinterface

// File: rtl/conv_core_param_dot_k.sv
// One output channel: K*K signed products (S1) and sign-extended sum (S2). Requires K >= 2.
module conv_dot_k
  import conv_core_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int K     = DEF_K,
  parameter int ACC_W = acc_w(WIDTH, K)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s1_en,
  input  logic                        s2_en,
  input  logic [K*K*WIDTH-1:0]        act,
  input  logic [K*K*WIDTH-1:0]        wgt,
  output logic signed [ACC_W-1:0]     sum
);

  localparam int TAPS = K * K;
  localparam int PW   = 2 * WIDTH;

  logic signed [PW-1:0]    prod [TAPS];
  logic signed [ACC_W-1:0] sum_c;

  function automatic logic signed [PW-1:0] smul(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic signed [PW-1:0] ae;
    logic signed [PW-1:0] be;
    ae = {{WIDTH{a[WIDTH-1]}}, a};
    be = {{WIDTH{b[WIDTH-1]}}, b};
    return ae * be;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) prod[i] <= '0;
    end else if (s1_en) begin
      for (int i = 0; i < TAPS; i++)
        prod[i] <= smul(act[i*WIDTH +: WIDTH], wgt[i*WIDTH +: WIDTH]);
    end
  end

  // Written as a chain; synthesis balances it into a tree.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < TAPS; i++)
      sum_c = sum_c + {{(ACC_W-PW){prod[i][PW-1]}}, prod[i]};
  end

  always_ff @(posedge clk) begin
    if (rst)        sum <= '0;
    else if (s2_en) sum <= sum_c;
  end

endmodule

// File: rtl/conv_core_param.sv
// KxK multi-channel convolution core: serial kernel load FSM plus a 3-stage dot-product pipe.
// Optional build macro CONV_CORE_RELU_EN clamps negative psums to zero in the output stage.
//
// state    | meaning
// IDLE     | kernel usable when kernel_valid; windows accepted
// LOAD     | capturing taps while weight_load=1, pausing while 0
// WAIT_LOW | last tap captured; wait for weight_load to drop
module conv_core_param
  import conv_core_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int K      = DEF_K,
  parameter int OUT_CH = DEF_OUT_CH
) (
  input  logic             clk,
  input  logic             rst,
  conv_core_param_if.slave bus
);

  localparam int ACC_W = acc_w(WIDTH, K);
  localparam int TAPS  = K * K;
  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        wr_idx;
  logic                    tap_wr;
  logic                    last_tap;
  logic                    kernel_valid;
  logic                    done_q;
  logic                    act_ready;
  logic                    accept;
  logic [TAPS*WIDTH-1:0]   kern [OUT_CH];
  logic signed [ACC_W-1:0] s2_sum [OUT_CH];
  logic                    s1_vld, s2_vld, psum_vld_q;
  logic [OUT_CH*ACC_W-1:0] psum_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (bus.weight_load) state_nxt = last_tap ? WAIT_LOW : LOAD;
      LOAD:     if (bus.weight_load && last_tap) state_nxt = WAIT_LOW;
      WAIT_LOW: if (!bus.weight_load) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // The IDLE->LOAD cycle already carries tap 0, so the write index ignores cnt there.
  always_comb begin
    act_ready = kernel_valid && (state == IDLE);
    tap_wr    = bus.weight_load && ((state == IDLE) || (state == LOAD));
    wr_idx    = (state == IDLE) ? '0 : cnt;
    last_tap  = (wr_idx == CNT_W'(TAPS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      kernel_valid <= 1'b0;
      done_q       <= 1'b0;
      for (int c = 0; c < OUT_CH; c++) kern[c] <= '0;
    end else begin
      done_q <= tap_wr && last_tap;
      if (tap_wr) begin
        for (int c = 0; c < OUT_CH; c++)
          kern[c][int'(wr_idx)*WIDTH +: WIDTH] <= bus.weight_in[c*WIDTH +: WIDTH];
        cnt <= last_tap ? '0 : wr_idx + CNT_W'(1);
      end
      if ((state == IDLE) && bus.weight_load) kernel_valid <= 1'b0;
      if (tap_wr && last_tap)                 kernel_valid <= 1'b1;
    end
  end

  assign accept = bus.act_valid && act_ready;

  for (genvar c = 0; c < OUT_CH; c++) begin : g_ch
    conv_dot_k #(
      .WIDTH (WIDTH),
      .K     (K),
      .ACC_W (ACC_W)
    ) u_dot (
      .clk   (clk),
      .rst   (rst),
      .s1_en (accept),
      .s2_en (s1_vld),
      .act   (bus.act_win),
      .wgt   (kern[c]),
      .sum   (s2_sum[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld     <= 1'b0;
      s2_vld     <= 1'b0;
      psum_vld_q <= 1'b0;
      psum_q     <= '0;
    end else begin
      s1_vld     <= accept;
      s2_vld     <= s1_vld;
      psum_vld_q <= s2_vld;
      if (s2_vld) begin
        for (int c = 0; c < OUT_CH; c++) begin
`ifdef CONV_CORE_RELU_EN
          psum_q[c*ACC_W +: ACC_W] <= s2_sum[c][ACC_W-1] ? '0 : s2_sum[c];
`else
          psum_q[c*ACC_W +: ACC_W] <= s2_sum[c];
`endif
        end
      end
    end
  end

  assign bus.weight_load_done = done_q;
  assign bus.act_ready        = act_ready;
  assign bus.psum_out         = psum_q;
  assign bus.psum_vld         = psum_vld_q;

endmodule

// File: tb/tb_conv_core_param.sv
// Directed bench for conv_core_param at WIDTH=8, K=3, OUT_CH=4 (ACC_W=20).
module tb_conv_core_param;

  localparam int WIDTH  = 8;
  localparam int K      = 3;
  localparam int OUT_CH = 4;
  localparam int TAPS   = 9;
  localparam int ACC_W  = 20;
  localparam int WW     = TAPS * WIDTH;
  localparam int PW     = OUT_CH * ACC_W;
  localparam int NV     = 10;

  typedef struct {
    logic [WW-1:0] win;
    logic [PW-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_core_param_if #(.WIDTH(WIDTH), .K(K), .OUT_CH(OUT_CH)) bus();

  conv_core_param #(.WIDTH(WIDTH), .K(K), .OUT_CH(OUT_CH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   tests = 0;
  int   fails = 0;
  int   kern_m [OUT_CH][TAPS];
  int   off [TAPS] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
  vec_t vecs [NV];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint psum_ch(input logic [PW-1:0] p, input int c);
    logic signed [ACC_W-1:0] v;
    v = p[c*ACC_W +: ACC_W];
    return longint'(v);
  endfunction

  function automatic logic [WW-1:0] flat_win(input int v);
    logic [WIDTH-1:0] b;
    b = v[WIDTH-1:0];
    return {TAPS{b}};
  endfunction

  // Serial load from kern_m; optional pause after tap pause_after, extra hold cycles after
  // the last tap, and act_valid held high during the load to show windows are dropped.
  task automatic load_kernel(input int pause_after, input int pause_len,
                             input int hold_extra, input bit poke_act);
    int dn;
    dn = 0;
    for (int i = 0; i < TAPS; i++) begin
      bus.weight_load = 1'b1;
      for (int c = 0; c < OUT_CH; c++)
        bus.weight_in[c*WIDTH +: WIDTH] = WIDTH'(kern_m[c][i]);
      tick;
      if (poke_act) begin
        bus.act_valid = 1'b1;
        bus.act_win   = flat_win(1);
        check("load_no_psum", bus.psum_vld, 0);
      end
      check("load_ready_low", bus.act_ready, 0);
      check("done_timing", bus.weight_load_done, (i == TAPS - 1) ? 1 : 0);
      if (bus.weight_load_done) dn++;
      if (i == pause_after) begin
        for (int p = 0; p < pause_len; p++) begin
          bus.weight_load = 1'b0;
          bus.weight_in   = {OUT_CH{8'h55}};
          tick;
          check("pause_ready_low", bus.act_ready, 0);
          check("pause_no_done", bus.weight_load_done, 0);
          if (poke_act) check("pause_no_psum", bus.psum_vld, 0);
        end
      end
    end
    for (int h = 0; h < hold_extra; h++) begin
      bus.weight_load = 1'b1;
      bus.weight_in   = {OUT_CH{8'h33}};
      tick;
      check("hold_ready_low", bus.act_ready, 0);
      if (bus.weight_load_done) dn++;
    end
    bus.weight_load = 1'b0;
    bus.act_valid   = 1'b0;
    tick;
    check("done_count", dn, 1);
    check("ready_after_load", bus.act_ready, 1);
    if (poke_act) begin
      for (int w = 0; w < 4; w++) begin
        tick;
        check("dropped_win_no_psum", bus.psum_vld, 0);
      end
    end
  endtask

  // One window, then watch 6 cycles: first psum_vld cycle index and number of valid cycles.
  task automatic send_window(input logic [WW-1:0] win, output logic [PW-1:0] ps,
                             output int lat, output int nv);
    bus.act_win   = win;
    bus.act_valid = 1'b1;
    tick;
    bus.act_valid = 1'b0;
    lat = -1;
    nv  = 0;
    ps  = '0;
    for (int k = 1; k <= 6; k++) begin
      if (bus.psum_vld) begin
        if (lat < 0) begin
          lat = k;
          ps  = bus.psum_out;
        end
        nv++;
      end
      tick;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [PW-1:0] ps;
    int            lat;
    int            nv;
    longint        relu_exp;

    rst             = 1'b1;
    bus.weight_load = 1'b0;
    bus.weight_in   = '0;
    bus.act_valid   = 1'b0;
    bus.act_win     = '0;
    tick;
    tick;
    check("rst_ready", bus.act_ready, 0);
    check("rst_done", bus.weight_load_done, 0);
    check("rst_vld", bus.psum_vld, 0);
    check("rst_psum", (bus.psum_out == '0) ? 1 : 0, 1);
    rst = 1'b0;
    tick;

    // No kernel yet: offered windows are dropped.
    bus.act_win   = flat_win(1);
    bus.act_valid = 1'b1;
    tick;
    tick;
    bus.act_valid = 1'b0;
    for (int w = 0; w < 4; w++) begin
      check("nokern_no_psum", bus.psum_vld, 0);
      tick;
    end

    // Kernel ch c tap i = i+1+c, caller drops weight_load on the done pulse.
    for (int c = 0; c < OUT_CH; c++)
      for (int i = 0; i < TAPS; i++) kern_m[c][i] = i + 1 + c;
    load_kernel(-1, 0, 0, 1'b0);

    send_window(flat_win(1), ps, lat, nv);
    check("ones_latency", lat, 3);
    check("ones_vld_cycles", nv, 1);
    check("ones_ch0", psum_ch(ps, 0), 45);
    check("ones_ch1", psum_ch(ps, 1), 54);
    check("ones_ch2", psum_ch(ps, 2), 63);
    check("ones_ch3", psum_ch(ps, 3), 72);

    // Back-to-back windows; ch c = 45*ai + 555 + c*(9*ai + 81) for this kernel.
    for (int ai = 0; ai < NV; ai++) begin
      for (int i = 0; i < TAPS; i++)
        vecs[ai].win[i*WIDTH +: WIDTH] = WIDTH'(ai + off[i]);
      for (int c = 0; c < OUT_CH; c++)
        vecs[ai].exp[c*ACC_W +: ACC_W] = ACC_W'(45*ai + 555 + c*(9*ai + 81));
    end
    check("b2b_ready", bus.act_ready, 1);
    for (int n = 0; n < NV + 2; n++) begin
      if (n < NV) begin
        bus.act_win   = vecs[n].win;
        bus.act_valid = 1'b1;
      end else begin
        bus.act_valid = 1'b0;
      end
      tick;
      if (n >= 2) begin
        check("b2b_vld", bus.psum_vld, 1);
        for (int c = 0; c < OUT_CH; c++)
          check($sformatf("b2b_w%0d_ch%0d", n - 2, c), psum_ch(bus.psum_out, c),
                psum_ch(vecs[n-2].exp, c));
      end
    end
    tick;
    check("b2b_vld_end", bus.psum_vld, 0);
    check("b2b_hold_ch0", psum_ch(bus.psum_out, 0), 45*9 + 555);

    // Paused load with act_valid offered throughout; junk on weight_in while paused.
    for (int c = 0; c < OUT_CH; c++)
      for (int i = 0; i < TAPS; i++) kern_m[c][i] = (i + 1) * (c + 1);
    load_kernel(4, 2, 0, 1'b1);
    send_window(flat_win(1), ps, lat, nv);
    check("pause_latency", lat, 3);
    for (int c = 0; c < OUT_CH; c++)
      check($sformatf("pause_ch%0d", c), psum_ch(ps, c), 45 * (c + 1));

    // Extremes, with weight_load held 3 cycles past done carrying junk.
    for (int c = 0; c < OUT_CH; c++)
      for (int i = 0; i < TAPS; i++) kern_m[c][i] = -128;
    load_kernel(-1, 0, 3, 1'b0);
    send_window(flat_win(-128), ps, lat, nv);
    for (int c = 0; c < OUT_CH; c++)
      check($sformatf("max_ch%0d", c), psum_ch(ps, c), 147456);

    // Negative psum on ch0.
    for (int c = 0; c < OUT_CH; c++)
      for (int i = 0; i < TAPS; i++) kern_m[c][i] = (c == 0) ? -1 : 2;
    load_kernel(-1, 0, 0, 1'b0);
    send_window(flat_win(1), ps, lat, nv);
`ifdef CONV_CORE_RELU_EN
    relu_exp = 0;
`else
    relu_exp = -9;
`endif
    check("neg_ch0", psum_ch(ps, 0), relu_exp);
    check("neg_ch1", psum_ch(ps, 1), 18);

    // Reset one cycle after an accepted window.
    check("rst_seq_ready", bus.act_ready, 1);
    bus.act_win   = flat_win(3);
    bus.act_valid = 1'b1;
    tick;
    bus.act_valid = 1'b0;
    rst           = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst_psum", (bus.psum_out == '0) ? 1 : 0, 1);
    for (int w = 0; w < 6; w++) begin
      check("midrst_no_vld", bus.psum_vld, 0);
      check("midrst_ready", bus.act_ready, 0);
      tick;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
